// File: rtl/fetch_prefetch_q_pkg.sv
// Shared definitions for the fetch / prefetch-queue block.
package fetch_prefetch_q_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned PC_INC_DEF = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTING = 2'd1,
    ST_HALTED  = 2'd2
  } fetch_state_e;

  // Counter width able to hold 0..depth inclusive (pointer width + 1).
  function automatic int unsigned cnt_w(input int unsigned depth);
    return ((depth > 1) ? $clog2(depth) : 1) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO with occupancy count and synchronous flush; head is zero when empty.
module fetch_fifo
  import fetch_prefetch_q_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned CNT_W = cnt_w(DEPTH);
  localparam int unsigned PTR_W = CNT_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage array; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_q.sv
// Fetch stage: sequential PC requests to instruction memory, PC-tagged prefetch queue toward decode.
module fetch_prefetch_q
  import fetch_prefetch_q_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned PC_INC   = PC_INC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic              halted,
  output logic              err
);

  localparam int unsigned QW     = DATA_W + ADDR_W;
  localparam int unsigned QCNT_W = cnt_w(DEPTH);
  localparam int unsigned OUT_W  = cnt_w(MAX_OUT);
  localparam int unsigned SUM_W  = QCNT_W + 1;
  localparam logic [ADDR_W-1:0] INC      = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] INC_MASK = ADDR_W'(PC_INC - 1);

  fetch_state_e      state;
  logic              armed;
  logic [ADDR_W-1:0] fetch_pc;
  logic [OUT_W-1:0]  discard;
  logic [ADDR_W:0]   pc_sum;

  logic [QW-1:0]     q_rdata;
  logic [QCNT_W-1:0] q_count;
  logic              q_full, q_empty, q_push, q_pop;
  logic [ADDR_W-1:0] p_rdata;
  logic [OUT_W-1:0]  p_count;
  logic              p_full, p_empty;

  logic accept, rsp_ok, rsp_keep, credit_ok, out_zero, misaligned;

  // Outstanding requests are the pending-PC FIFO occupancy; queue space is reserved for every one of them.
  assign credit_ok  = (SUM_W'(q_count) + SUM_W'(p_count)) < SUM_W'(DEPTH);
  assign req_valid  = armed && (state == ST_RUN) && !halt && !redir_valid && !p_full && credit_ok;
  assign req_addr   = fetch_pc;
  assign accept     = req_valid && req_ready;
  assign rsp_ok     = rsp_valid && !p_empty;
  assign rsp_keep   = rsp_ok && (discard == '0) && !redir_valid;
  assign q_push     = rsp_keep && !q_full;
  assign q_pop      = !q_empty && out_ready && !redir_valid;
  assign pc_sum     = {1'b0, fetch_pc} + (ADDR_W + 1)'(PC_INC);
  assign out_zero   = (p_count == OUT_W'(rsp_ok));
  assign misaligned = (redir_pc & INC_MASK) != '0;

  assign out_valid   = !q_empty;
  assign out_instr   = q_rdata[QW-1:ADDR_W];
  assign out_pc      = q_rdata[ADDR_W-1:0];
  assign out_pc_next = q_empty ? '0 : ADDR_W'(out_pc + INC);
  assign halted      = (state == ST_HALTED);

  fetch_fifo #(.WIDTH(QW), .DEPTH(DEPTH)) u_prefetch_q (
    .clk   (clk),
    .rst_n (rst),
    .flush (redir_valid),
    .push  (q_push),
    .wdata ({rsp_data, p_rdata}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUT)) u_pending_pc (
    .clk   (clk),
    .rst_n (rst),
    .flush (1'b0),
    .push  (accept),
    .wdata (fetch_pc),
    .pop   (rsp_ok),
    .rdata (p_rdata),
    .count (p_count),
    .full  (p_full),
    .empty (p_empty)
  );

  // Fetch PC: redirect target wins, otherwise advance on each accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= ADDR_W'(RESET_PC);
    end else if (redir_valid) begin
      fetch_pc <= redir_pc;
    end else if (accept) begin
      fetch_pc <= pc_sum[ADDR_W-1:0];
    end
  end

  // Responses still in flight at a redirect belong to the old path and are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      discard <= '0;
    end else if (redir_valid) begin
      discard <= p_count - OUT_W'(rsp_ok);
    end else if (rsp_ok && (discard != '0)) begin
      discard <= discard - OUT_W'(1);
    end
  end

  // Run/halt control; issue is held off for the first cycle out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_RUN:     if (halt) state <= ST_HALTING;
        ST_HALTING: if (!halt) state <= ST_RUN;
                    else if (out_zero) state <= ST_HALTED;
        ST_HALTED:  if (!halt) state <= ST_RUN;
        default:    state <= ST_RUN;
      endcase
    end
  end

  // Sticky error: PC wrap, misaligned redirect, or a response with nothing outstanding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if ((accept && pc_sum[ADDR_W]) || (redir_valid && misaligned) || (rsp_valid && p_empty)) begin
      err <= 1'b1;
    end
  end

endmodule
